// File: rtl/odev_display_pkg.sv
// Shared constants and helpers for the output-device 7-segment scanner.
package odev_display_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int unsigned cnt_width(input int unsigned prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/odev_display_scan_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder with blanking.
module hex7seg
  import odev_display_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_OFF : HEX_SEG[i_hex];

endmodule

// File: rtl/odev_display_scan.sv
// Scans three output-device bytes onto a 6-digit multiplexed common-anode display,
// snapshotting the bytes once per frame and blanking between digit slots.
module odev_display_scan
  import odev_display_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] odev0,
  input  logic [7:0] odev1,
  input  logic [7:0] odev2,
  input  logic       lz_blank_en,
  input  logic       freeze,
  output logic [5:0] an_bar,
  output logic [6:0] seg_bar,
  output logic       frame_tick
);

  localparam int unsigned CW = cnt_width(PRESCALE);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_dig;
  logic [23:0]   r_snap;
  logic [5:0]    r_an_bar;
  logic [6:0]    r_seg_bar;
  logic          r_frame_tick;

  logic          w_frame_start;
  logic          w_cnt_last;
  logic          w_blank_phase;
  logic [3:0]    w_nibble;
  logic [5:0]    w_zero;
  logic [5:0]    w_upper_zero;
  logic          w_lz_digit;
  logic          w_dec_blank;
  logic [6:0]    w_seg;

  assign w_frame_start = (r_cnt == '0) && (r_dig == 3'd0);
  assign w_cnt_last    = (r_cnt == CW'(PRESCALE - 1));
  assign w_blank_phase = (r_cnt < CW'(BLANK_CYCLES));

  // w_upper_zero[i] is set when snapshot digits 5..i are all zero.
  always_comb begin
    w_zero       = '0;
    w_upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_zero[i] = (r_snap[4*i +: 4] == 4'h0);
    end
    w_upper_zero[5] = w_zero[5];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_upper_zero[i] = w_zero[i] & w_upper_zero[i+1];
    end
  end

  always_comb begin
    w_nibble   = r_snap[3:0];
    w_lz_digit = 1'b0;
    unique case (r_dig)
      3'd0: begin w_nibble = r_snap[3:0];   w_lz_digit = 1'b0;            end
      3'd1: begin w_nibble = r_snap[7:4];   w_lz_digit = w_upper_zero[1]; end
      3'd2: begin w_nibble = r_snap[11:8];  w_lz_digit = w_upper_zero[2]; end
      3'd3: begin w_nibble = r_snap[15:12]; w_lz_digit = w_upper_zero[3]; end
      3'd4: begin w_nibble = r_snap[19:16]; w_lz_digit = w_upper_zero[4]; end
      default: begin w_nibble = r_snap[23:20]; w_lz_digit = w_upper_zero[5]; end
    endcase
  end

  assign w_dec_blank = w_blank_phase | (lz_blank_en & w_lz_digit);

  hex7seg u_hex7seg (
    .i_hex   (w_nibble),
    .i_blank (w_dec_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_dig        <= 3'd0;
      r_snap       <= '0;
      r_an_bar     <= 6'h3F;
      r_seg_bar    <= SEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_cnt_last) begin
        r_cnt <= '0;
        r_dig <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_frame_start && !freeze) begin
        r_snap <= {odev2, odev1, odev0};
      end
      r_frame_tick <= w_frame_start;
      r_an_bar     <= w_blank_phase ? 6'h3F : ~(6'd1 << r_dig);
      r_seg_bar    <= w_seg;
    end
  end

  assign an_bar     = r_an_bar;
  assign seg_bar    = r_seg_bar;
  assign frame_tick = r_frame_tick;

endmodule
